// File: rtl/scan_sched.sv
// Eight-digit multiplexed display scanner: double-buffered digit banks, per-slot
// blanking, masked scan order and a frame_done pulse at each scan wrap.
module scan_sched #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic       wr_ready,
    input  logic       commit,
    input  logic [7:0] en_mask,
    input  logic       freeze,
    output logic [3:0] D,
    output logic [2:0] AN,
    output logic       blank,
    output logic       frame_done,
    output logic [1:0] state_dbg
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      sel, sel_n;
    logic            commit_pend;
    logic [3:0]      shadow [8];
    logic [3:0]      active [8];
    logic [2:0]      first_sel, next_sel;
    logic            any_en, wrap, do_copy;

    assign wr_ready  = ~commit_pend;
    assign state_dbg = state;
    assign any_en    = |en_mask;

    // Lowest enabled digit, and the next enabled digit after sel (wrapping 7->0).
    // Iterating downwards lets the smallest index/offset win.
    always_comb begin
        first_sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (en_mask[i]) first_sel = 3'(i);
        end
        next_sel = sel;
        for (int i = 7; i >= 1; i--) begin
            if (en_mask[3'(sel + 3'(i))]) next_sel = 3'(sel + 3'(i));
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sel_n   = sel;
        wrap    = 1'b0;
        if (!freeze) begin
            case (state)
                IDLE: begin
                    if (any_en) begin
                        state_n = BLANK;
                        sel_n   = first_sel;
                        cnt_n   = '0;
                    end
                end
                BLANK, SHOW: begin
                    if (cnt == CNT_LAST) begin
                        cnt_n = '0;
                        if (!any_en) begin
                            state_n = IDLE;
                        end else begin
                            state_n = BLANK;
                            sel_n   = next_sel;
                            wrap    = (next_sel <= sel);
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                        if (state == BLANK && cnt == BLANK_END) state_n = SHOW;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        do_copy = commit_pend && (wrap || state == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            sel   <= 3'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sel   <= sel_n;
        end
    end

    // Outputs are registered from the state being entered, so they line up with state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            D          <= 4'd0;
            AN         <= 3'd0;
            blank      <= 1'b1;
            frame_done <= 1'b0;
        end else if (freeze) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= wrap;
            case (state_n)
                BLANK: begin
                    blank <= 1'b1;
                    D     <= 4'd0;
                    AN    <= sel_n;
                end
                SHOW: begin
                    blank <= 1'b0;
                    D     <= active[sel_n];
                    AN    <= sel_n;
                end
                default: begin
                    blank <= 1'b1;
                    D     <= 4'd0;
                end
            endcase
        end
    end

    // Shadow writes are locked out while a copy is pending, so the copy sees a stable bank.
    always_ff @(posedge clk) begin
        if (!rst) begin
            commit_pend <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= 4'd0;
                active[i] <= 4'd0;
            end
        end else begin
            if (do_copy) commit_pend <= 1'b0;
            else if (commit) commit_pend <= 1'b1;
            if (wr_en && !commit_pend) shadow[wr_addr] <= wr_data;
            if (do_copy) begin
                for (int i = 0; i < 8; i++) active[i] <= shadow[i];
            end
        end
    end

endmodule

// File: tb/tb_scan_sched.sv
// Directed bench for scan_sched with SCAN_DIV=4, BLANK_CYC=1 (1 blank + 3 show cycles per slot).
module tb_scan_sched;

    logic       clk = 1'b0;
    logic       rst, wr_en, commit, freeze;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [7:0] en_mask;
    logic       wr_ready, blank, frame_done;
    logic [3:0] D;
    logic [2:0] AN;
    logic [1:0] state_dbg;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    scan_sched #(.SCAN_DIV(4), .BLANK_CYC(1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .commit(commit), .en_mask(en_mask), .freeze(freeze),
        .D(D), .AN(AN), .blank(blank), .frame_done(frame_done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock, then check the registered display outputs.
    task automatic step(input string tag, input logic [2:0] an, input logic [3:0] d,
                        input logic bl, input logic fd);
        tick();
        chk({tag, ".AN"}, 8'(AN), 8'(an));
        chk({tag, ".D"}, 8'(D), 8'(d));
        chk({tag, ".blank"}, 8'(blank), 8'(bl));
        chk({tag, ".frame_done"}, 8'(frame_done), 8'(fd));
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'd0;
        commit = 1'b0; en_mask = 8'h00; freeze = 1'b0;

        tick();
        step("reset", 3'd0, 4'h0, 1'b1, 1'b0);
        chk("reset.wr_ready", 8'(wr_ready), 8'd1);
        chk("reset.state", 8'(state_dbg), 8'd0);
        rst = 1'b1;

        // Preload d0=A, d1=5 and commit while idle
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'hA; tick();
        wr_addr = 3'd1; wr_data = 4'h5; tick();
        wr_en = 1'b0; commit = 1'b1; tick();
        chk("pend.wr_ready", 8'(wr_ready), 8'd0);
        commit = 1'b0; tick();
        chk("idle_copy.wr_ready", 8'(wr_ready), 8'd1);
        chk("idle_copy.state", 8'(state_dbg), 8'd0);

        // Two-digit scan
        en_mask = 8'h03;
        step("m03.d0b", 3'd0, 4'h0, 1'b1, 1'b0);
        chk("m03.state_blank", 8'(state_dbg), 8'd1);
        repeat (3) step("m03.d0s", 3'd0, 4'hA, 1'b0, 1'b0);
        step("m03.d1b", 3'd1, 4'h0, 1'b1, 1'b0);
        repeat (3) step("m03.d1s", 3'd1, 4'h5, 1'b0, 1'b0);
        step("m03.wrap", 3'd0, 4'h0, 1'b1, 1'b1);
        step("m03.d0s2", 3'd0, 4'hA, 1'b0, 1'b0);

        // Mask 81 takes effect at the end of the current slot
        en_mask = 8'h81;
        repeat (2) step("m81.d0s", 3'd0, 4'hA, 1'b0, 1'b0);
        step("m81.d7b", 3'd7, 4'h0, 1'b1, 1'b0);
        repeat (3) step("m81.d7s", 3'd7, 4'h0, 1'b0, 1'b0);
        step("m81.wrap", 3'd0, 4'h0, 1'b1, 1'b1);
        step("m81.d0s", 3'd0, 4'hA, 1'b0, 1'b0);

        // Write d0=3 with commit mid-frame; a later write while not ready is dropped
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'h3; commit = 1'b1;
        step("cm.old0", 3'd0, 4'hA, 1'b0, 1'b0);
        chk("cm.wr_ready_low", 8'(wr_ready), 8'd0);
        commit = 1'b0; wr_addr = 3'd1; wr_data = 4'hF;
        step("cm.old1", 3'd0, 4'hA, 1'b0, 1'b0);
        wr_en = 1'b0;
        step("cm.d7b", 3'd7, 4'h0, 1'b1, 1'b0);
        chk("cm.wr_ready_still_low", 8'(wr_ready), 8'd0);
        repeat (3) step("cm.d7s", 3'd7, 4'h0, 1'b0, 1'b0);
        step("cm.wrap", 3'd0, 4'h0, 1'b1, 1'b1);
        chk("cm.wr_ready_back", 8'(wr_ready), 8'd1);
        en_mask = 8'h06;
        repeat (3) step("cm.new0", 3'd0, 4'h3, 1'b0, 1'b0);
        step("m06.d1b", 3'd1, 4'h0, 1'b1, 1'b0);
        repeat (3) step("m06.d1_not_F", 3'd1, 4'h5, 1'b0, 1'b0);
        step("m06.d2b", 3'd2, 4'h0, 1'b1, 1'b0);
        step("m06.d2s", 3'd2, 4'h0, 1'b0, 1'b0);

        // Clear mask mid-slot of digit 2, with a pending commit of d2=9
        en_mask = 8'h00; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'h9; commit = 1'b1;
        step("off.d2s_a", 3'd2, 4'h0, 1'b0, 1'b0);
        wr_en = 1'b0; commit = 1'b0;
        step("off.d2s_b", 3'd2, 4'h0, 1'b0, 1'b0);
        step("off.idle", 3'd2, 4'h0, 1'b1, 1'b0);
        chk("off.state_idle", 8'(state_dbg), 8'd0);
        chk("off.pend_kept", 8'(wr_ready), 8'd0);
        step("off.idle_copy", 3'd2, 4'h0, 1'b1, 1'b0);
        chk("off.copied", 8'(wr_ready), 8'd1);
        en_mask = 8'h04;
        step("m04.d2b", 3'd2, 4'h0, 1'b1, 1'b0);
        step("m04.d2s", 3'd2, 4'h9, 1'b0, 1'b0);

        // Freeze five cycles in SHOW while committing d2=7
        freeze = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 4'h7; commit = 1'b1;
        step("frz.0", 3'd2, 4'h9, 1'b0, 1'b0);
        chk("frz.commit_latched", 8'(wr_ready), 8'd0);
        wr_en = 1'b0; commit = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step("frz.hold", 3'd2, 4'h9, 1'b0, 1'b0);
            chk("frz.state", 8'(state_dbg), 8'd2);
        end
        freeze = 1'b0;
        repeat (2) step("frz.resume", 3'd2, 4'h9, 1'b0, 1'b0);
        step("frz.wrap", 3'd2, 4'h0, 1'b1, 1'b1);
        step("frz.new", 3'd2, 4'h7, 1'b0, 1'b0);

        // Reset in SHOW with a commit pending
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 4'hC; commit = 1'b1;
        step("rs.pre", 3'd2, 4'h7, 1'b0, 1'b0);
        chk("rs.pend", 8'(wr_ready), 8'd0);
        wr_en = 1'b0; commit = 1'b0; rst = 1'b0;
        step("rs.mid", 3'd0, 4'h0, 1'b1, 1'b0);
        chk("rs.wr_ready", 8'(wr_ready), 8'd1);
        chk("rs.state", 8'(state_dbg), 8'd0);
        rst = 1'b1;
        step("rs.d2b", 3'd2, 4'h0, 1'b1, 1'b0);
        step("rs.active0", 3'd2, 4'h0, 1'b0, 1'b0);
        commit = 1'b1;
        step("rs.c1", 3'd2, 4'h0, 1'b0, 1'b0);
        commit = 1'b0;
        step("rs.c2", 3'd2, 4'h0, 1'b0, 1'b0);
        step("rs.wrap", 3'd2, 4'h0, 1'b1, 1'b1);
        step("rs.shadow0", 3'd2, 4'h0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
